// File: rtl/filter_peak_detector.sv
// Peak detector for the trapezoidal shaper output.
// Finds the maximum of each pulse above a signed threshold and reports it
// as an {amplitude, timestamp} event over a valid/ready handshake.
// A holdoff window and a re-arm rule stop one pulse from triggering twice.
// Events that arrive while an earlier one is still waiting are dropped and counted.
module filter_peak_detector #(
  parameter int SIZE_FILTER_DATA = 14,
  parameter int TS_WIDTH         = 32,
  parameter int HOLDOFF_CYCLES   = 16,
  parameter int LOST_WIDTH       = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic signed [SIZE_FILTER_DATA+3:0] filter_data,
  input  logic signed [SIZE_FILTER_DATA+3:0] threshold,
  output logic                               peak_valid,
  input  logic                               peak_ready,
  output logic signed [SIZE_FILTER_DATA+3:0] peak_amplitude,
  output logic [TS_WIDTH-1:0]                peak_time,
  output logic [LOST_WIDTH-1:0]              lost_count,
  output logic                               busy
);

  localparam int W  = SIZE_FILTER_DATA + 4;
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HW-1:0] HOLDOFF_LOAD = HW'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    RISING,
    HOLDOFF,
    WAIT_BELOW
  } state_t;

  state_t state_q, state_d;

  logic [TS_WIDTH-1:0]   timeStamp_q;
  logic signed [W-1:0]   peakMax_q, peakMax_d;
  logic [TS_WIDTH-1:0]   maxTime_q, maxTime_d;
  logic [HW-1:0]         holdCnt_q, holdCnt_d;
  logic                  eventValid_q, eventValid_d;
  logic signed [W-1:0]   eventAmp_q, eventAmp_d;
  logic [TS_WIDTH-1:0]   eventTime_q, eventTime_d;
  logic [LOST_WIDTH-1:0] lostCnt_q, lostCnt_d;

  logic startPulse;
  logic raiseMax;
  logic eventWrite;
  logic holdTick;

  // Free-running sample timestamp; runs regardless of enable and wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeStamp_q <= '0;
    end else begin
      timeStamp_q <= timeStamp_q + TS_WIDTH'(1);
    end
  end

  // Detector state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision; a low enable pulls every state back to IDLE.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (filter_data > threshold) begin
            state_d = RISING;
          end
        end
        RISING: begin
          if (filter_data < peakMax_q) begin
            state_d = HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (holdCnt_q <= HW'(1)) begin
            state_d = (filter_data > threshold) ? WAIT_BELOW : IDLE;
          end
        end
        WAIT_BELOW: begin
          if (filter_data <= threshold) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State-decoded actions; equal samples in RISING neither raise the max nor end the pulse.
  always_comb begin
    startPulse = 1'b0;
    raiseMax   = 1'b0;
    eventWrite = 1'b0;
    holdTick   = 1'b0;
    if (enable) begin
      case (state_q)
        IDLE:    startPulse = (filter_data > threshold);
        RISING: begin
          raiseMax   = (filter_data > peakMax_q);
          eventWrite = (filter_data < peakMax_q);
        end
        HOLDOFF: holdTick = 1'b1;
        default: ;
      endcase
    end
  end

  // Datapath next values: running maximum, holdoff countdown and the output event slot.
  always_comb begin
    peakMax_d    = peakMax_q;
    maxTime_d    = maxTime_q;
    holdCnt_d    = holdCnt_q;
    eventValid_d = eventValid_q;
    eventAmp_d   = eventAmp_q;
    eventTime_d  = eventTime_q;
    lostCnt_d    = lostCnt_q;

    if (startPulse || raiseMax) begin
      peakMax_d = filter_data;
      maxTime_d = timeStamp_q;
    end

    if (eventWrite) begin
      holdCnt_d = HOLDOFF_LOAD;
    end else if (holdTick) begin
      holdCnt_d = (holdCnt_q <= HW'(1)) ? '0 : holdCnt_q - HW'(1);
    end

    if (eventValid_q && peak_ready) begin
      eventValid_d = 1'b0;
    end

    if (eventWrite) begin
      if (!eventValid_q || peak_ready) begin
        eventValid_d = 1'b1;
        eventAmp_d   = peakMax_q;
        eventTime_d  = maxTime_q;
      end else if (lostCnt_q != '1) begin
        lostCnt_d = lostCnt_q + LOST_WIDTH'(1);
      end
    end
  end

  // Datapath registers; reset discards any pulse in progress and any pending event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peakMax_q    <= '0;
      maxTime_q    <= '0;
      holdCnt_q    <= '0;
      eventValid_q <= 1'b0;
      eventAmp_q   <= '0;
      eventTime_q  <= '0;
      lostCnt_q    <= '0;
    end else begin
      peakMax_q    <= peakMax_d;
      maxTime_q    <= maxTime_d;
      holdCnt_q    <= holdCnt_d;
      eventValid_q <= eventValid_d;
      eventAmp_q   <= eventAmp_d;
      eventTime_q  <= eventTime_d;
      lostCnt_q    <= lostCnt_d;
    end
  end

  assign peak_valid     = eventValid_q;
  assign peak_amplitude = eventAmp_q;
  assign peak_time      = eventTime_q;
  assign lost_count     = lostCnt_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_filter_peak_detector.sv
// Directed testbench for filter_peak_detector.
// Built with an 8-bit timestamp, a 4-cycle holdoff and a 2-bit lost counter
// so wrap-around and counter saturation are reachable in a short run.
module tb_filter_peak_detector;

  localparam int SFD  = 14;
  localparam int W    = SFD + 4;
  localparam int TSW  = 8;
  localparam int HOLD = 4;
  localparam int LW   = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic signed [W-1:0]  filter_data;
  logic signed [W-1:0]  threshold;
  logic                 peak_valid;
  logic                 peak_ready;
  logic signed [W-1:0]  peak_amplitude;
  logic [TSW-1:0]       peak_time;
  logic [LW-1:0]        lost_count;
  logic                 busy;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    bit    rst;
    bit    en;
    int    thr;
    int    data;
    bit    ready;
    bit    expValid;
    int    expAmp;
    int    expTime;
    int    expLost;
    bit    expBusy;
    string name;
  } vec_t;

  vec_t vecs[$];

  filter_peak_detector #(
    .SIZE_FILTER_DATA(SFD),
    .TS_WIDTH(TSW),
    .HOLDOFF_CYCLES(HOLD),
    .LOST_WIDTH(LW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .filter_data(filter_data),
    .threshold(threshold),
    .peak_valid(peak_valid),
    .peak_ready(peak_ready),
    .peak_amplitude(peak_amplitude),
    .peak_time(peak_time),
    .lost_count(lost_count),
    .busy(busy)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  function automatic void addVec(bit rst, bit en, int thr, int data, bit ready,
                                 bit expValid, int expAmp, int expTime, int expLost,
                                 bit expBusy, string name);
    vec_t v;
    v.rst = rst;  v.en = en;  v.thr = thr;  v.data = data;  v.ready = ready;
    v.expValid = expValid;  v.expAmp = expAmp;  v.expTime = expTime;
    v.expLost = expLost;  v.expBusy = expBusy;  v.name = name;
    vecs.push_back(v);
  endfunction

  // Holds reset over one clock edge and releases it at a falling edge, so
  // the next rising edge is the first post-reset edge (timestamp 0).
  task automatic applyReset();
    reset       = 1'b1;
    enable      = 1'b1;
    filter_data = '0;
    peak_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Presents one sample, lets one rising edge capture it, then waits 1 ns.
  task automatic applyStimulus(input bit en, input int thr, input int data, input bit ready);
    enable      = en;
    threshold   = W'(thr);
    filter_data = W'(data);
    peak_ready  = ready;
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input bit expValid, input int expAmp,
                             input int expTime, input int expLost, input bit expBusy);
    checkVal({name, " valid"}, int'(peak_valid), int'(expValid));
    if (expValid) begin
      checkVal({name, " amp"}, int'(peak_amplitude), expAmp);
      checkVal({name, " time"}, int'(peak_time), expTime);
    end
    checkVal({name, " lost"}, int'(lost_count), expLost);
    checkVal({name, " busy"}, int'(busy), int'(expBusy));
  endtask

  task automatic checkAllZero(input string name);
    checkVal({name, " valid"}, int'(peak_valid), 0);
    checkVal({name, " amp"}, int'(peak_amplitude), 0);
    checkVal({name, " time"}, int'(peak_time), 0);
    checkVal({name, " lost"}, int'(lost_count), 0);
    checkVal({name, " busy"}, int'(busy), 0);
  endtask

  initial begin
    // Basic peak: 0,50,150,300,420,410,... -> 420 @ ts 4, valid for one cycle
    addVec(1, 1, 100,   0, 1, 0,   0, 0, 0, 0, "A0");
    addVec(0, 1, 100,  50, 1, 0,   0, 0, 0, 0, "A1");
    addVec(0, 1, 100, 150, 1, 0,   0, 0, 0, 1, "A2");
    addVec(0, 1, 100, 300, 1, 0,   0, 0, 0, 1, "A3");
    addVec(0, 1, 100, 420, 1, 0,   0, 0, 0, 1, "A4");
    addVec(0, 1, 100, 410, 1, 1, 420, 4, 0, 1, "A5");
    addVec(0, 1, 100, 200, 1, 0,   0, 0, 0, 1, "A6");
    addVec(0, 1, 100,   0, 1, 0,   0, 0, 0, 1, "A7");
    addVec(0, 1, 100,   0, 1, 0,   0, 0, 0, 1, "A8");
    addVec(0, 1, 100,   0, 1, 0,   0, 0, 0, 0, "A9");
    // Negative threshold, equal maxima: first 80 (ts 2) wins
    addVec(1, 1, -50, -100, 1, 0,  0, 0, 0, 0, "B0");
    addVec(0, 1, -50,  -20, 1, 0,  0, 0, 0, 1, "B1");
    addVec(0, 1, -50,   80, 1, 0,  0, 0, 0, 1, "B2");
    addVec(0, 1, -50,   80, 1, 0,  0, 0, 0, 1, "B3");
    addVec(0, 1, -50,   60, 1, 1, 80, 2, 0, 1, "B4");
    addVec(0, 1, -50, -100, 1, 0,  0, 0, 0, 1, "B5");
    addVec(0, 1, -50, -100, 1, 0,  0, 0, 0, 1, "B6");
    addVec(0, 1, -50, -100, 1, 0,  0, 0, 0, 1, "B7");
    addVec(0, 1, -50, -100, 1, 0,  0, 0, 0, 0, "B8");
    // Holdoff then WAIT_BELOW while data stays above threshold, then re-arm
    addVec(1, 1, 100, 500, 1, 0,   0,  0, 0, 1, "C0");
    addVec(0, 1, 100, 200, 1, 1, 500,  0, 0, 1, "C1");
    addVec(0, 1, 100, 200, 1, 0,   0,  0, 0, 1, "C2");
    addVec(0, 1, 100, 200, 1, 0,   0,  0, 0, 1, "C3");
    addVec(0, 1, 100, 200, 1, 0,   0,  0, 0, 1, "C4");
    addVec(0, 1, 100, 200, 1, 0,   0,  0, 0, 1, "C5");
    addVec(0, 1, 100, 300, 1, 0,   0,  0, 0, 1, "C6");
    addVec(0, 1, 100, 250, 1, 0,   0,  0, 0, 1, "C7");
    addVec(0, 1, 100, 100, 1, 0,   0,  0, 0, 0, "C8");
    addVec(0, 1, 100, 150, 1, 0,   0,  0, 0, 1, "C9");
    addVec(0, 1, 100, 350, 1, 0,   0,  0, 0, 1, "C10");
    addVec(0, 1, 100, 120, 1, 1, 350, 10, 0, 1, "C11");
    addVec(0, 1, 100,   0, 1, 0,   0,  0, 0, 1, "C12");
    // Backpressure: first event held, later ones counted, counter saturates at 3
    addVec(1, 1, 100, 200, 0, 0,   0,  0, 0, 1, "D0");
    addVec(0, 1, 100, 100, 0, 1, 200,  0, 0, 1, "D1");
    addVec(0, 1, 100,   0, 0, 1, 200,  0, 0, 1, "D2");
    addVec(0, 1, 100,   0, 0, 1, 200,  0, 0, 1, "D3");
    addVec(0, 1, 100,   0, 0, 1, 200,  0, 0, 1, "D4");
    addVec(0, 1, 100,   0, 0, 1, 200,  0, 0, 0, "D5");
    addVec(0, 1, 100, 300, 0, 1, 200,  0, 0, 1, "D6");
    addVec(0, 1, 100,  50, 0, 1, 200,  0, 1, 1, "D7");
    addVec(0, 1, 100,   0, 0, 1, 200,  0, 1, 1, "D8");
    addVec(0, 1, 100,   0, 0, 1, 200,  0, 1, 1, "D9");
    addVec(0, 1, 100,   0, 0, 1, 200,  0, 1, 1, "D10");
    addVec(0, 1, 100,   0, 0, 1, 200,  0, 1, 0, "D11");
    addVec(0, 1, 100, 400, 0, 1, 200,  0, 1, 1, "D12");
    addVec(0, 1, 100,   0, 0, 1, 200,  0, 2, 1, "D13");
    addVec(0, 1, 100,   0, 0, 1, 200,  0, 2, 1, "D14");
    addVec(0, 1, 100,   0, 0, 1, 200,  0, 2, 1, "D15");
    addVec(0, 1, 100,   0, 0, 1, 200,  0, 2, 1, "D16");
    addVec(0, 1, 100,   0, 0, 1, 200,  0, 2, 0, "D17");
    addVec(0, 1, 100,   0, 1, 0,   0,  0, 2, 0, "D18");
    addVec(0, 1, 100, 200, 0, 0,   0,  0, 2, 1, "D19");
    addVec(0, 1, 100,   0, 0, 1, 200, 19, 2, 1, "D20");
    addVec(0, 1, 100,   0, 0, 1, 200, 19, 2, 1, "D21");
    addVec(0, 1, 100,   0, 0, 1, 200, 19, 2, 1, "D22");
    addVec(0, 1, 100,   0, 0, 1, 200, 19, 2, 1, "D23");
    addVec(0, 1, 100,   0, 0, 1, 200, 19, 2, 0, "D24");
    addVec(0, 1, 100, 300, 0, 1, 200, 19, 2, 1, "D25");
    addVec(0, 1, 100,   0, 0, 1, 200, 19, 3, 1, "D26");
    addVec(0, 1, 100,   0, 0, 1, 200, 19, 3, 1, "D27");
    addVec(0, 1, 100,   0, 0, 1, 200, 19, 3, 1, "D28");
    addVec(0, 1, 100,   0, 0, 1, 200, 19, 3, 1, "D29");
    addVec(0, 1, 100,   0, 0, 1, 200, 19, 3, 0, "D30");
    addVec(0, 1, 100, 300, 0, 1, 200, 19, 3, 1, "D31");
    addVec(0, 1, 100,   0, 0, 1, 200, 19, 3, 1, "D32");
    // Accept and new event on the same edge: valid stays high, nothing lost
    addVec(1, 1, 100, 200, 0, 0,   0, 0, 0, 1, "E0");
    addVec(0, 1, 100, 100, 0, 1, 200, 0, 0, 1, "E1");
    addVec(0, 1, 100,   0, 0, 1, 200, 0, 0, 1, "E2");
    addVec(0, 1, 100,   0, 0, 1, 200, 0, 0, 1, "E3");
    addVec(0, 1, 100,   0, 0, 1, 200, 0, 0, 1, "E4");
    addVec(0, 1, 100,   0, 0, 1, 200, 0, 0, 0, "E5");
    addVec(0, 1, 100, 300, 0, 1, 200, 0, 0, 1, "E6");
    addVec(0, 1, 100, 250, 1, 1, 300, 6, 0, 1, "E7");
    addVec(0, 1, 100,   0, 1, 0,   0, 0, 0, 1, "E8");
    // enable low: pending event kept, in-progress pulses abandoned
    addVec(1, 1, 100, 200, 0, 0,   0, 0, 0, 1, "G0");
    addVec(0, 1, 100, 100, 0, 1, 200, 0, 0, 1, "G1");
    addVec(0, 0, 100,   0, 0, 1, 200, 0, 0, 0, "G2");
    addVec(0, 1, 100, 300, 0, 1, 200, 0, 0, 1, "G3");
    addVec(0, 0, 100, 100, 0, 1, 200, 0, 0, 0, "G4");
    addVec(0, 1, 100,   0, 1, 0,   0, 0, 0, 0, "G5");
    addVec(0, 1, 100,  50, 1, 0,   0, 0, 0, 0, "G6");
    addVec(0, 1, 100, 300, 1, 0,   0, 0, 0, 1, "G7");
    addVec(0, 0, 100, 100, 1, 0,   0, 0, 0, 0, "G8");
    addVec(0, 1, 100,   0, 1, 0,   0, 0, 0, 0, "G9");

    // Reset state, sampled after a clock edge taken with reset high
    reset       = 1'b1;
    enable      = 1'b0;
    filter_data = '0;
    threshold   = '0;
    peak_ready  = 1'b0;
    @(negedge clk);
    checkAllZero("reset");

    foreach (vecs[i]) begin
      if (vecs[i].rst) applyReset();
      applyStimulus(vecs[i].en, vecs[i].thr, vecs[i].data, vecs[i].ready);
      checkOutput(vecs[i].name, vecs[i].expValid, vecs[i].expAmp, vecs[i].expTime,
                  vecs[i].expLost, vecs[i].expBusy);
    end

    // Reset mid-RISING with an event pending: everything cleared, nothing after release
    applyReset();
    applyStimulus(1, 100, 200, 0);
    applyStimulus(1, 100, 100, 0);
    checkOutput("R1", 1, 200, 0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 100, 0, 0);
    applyStimulus(1, 100, 300, 0);
    checkOutput("R6", 1, 200, 0, 0, 1);
    filter_data = W'(100);
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("R async");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 100, 0, 1);
      checkOutput("R after", 0, 0, 0, 0, 0);
    end

    // Timestamp wrap: rise at ts 255, peak at ts 0 after the wrap
    applyReset();
    for (int i = 0; i < 255; i++) applyStimulus(1, 100, 0, 1);
    applyStimulus(1, 100, 200, 1);
    checkOutput("T255", 0, 0, 0, 0, 1);
    applyStimulus(1, 100, 500, 1);
    applyStimulus(1, 100, 100, 1);
    checkOutput("Twrap", 1, 500, 0, 0, 1);
    applyStimulus(1, 100, 0, 1);
    checkOutput("Tdone", 0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/filter_peak_detector.md
Name: filter_peak_detector

Overview:
- Consumer at the output end of the trapezoidal shaping filter. Takes the signed shaped stream and finds each pulse maximum above a programmable threshold.
- For every pulse it emits one event: amplitude plus timestamp. Events are delivered through a valid/ready handshake to the readout.
- A holdoff window and a re-arm rule suppress double triggers on one pulse. Events dropped under readout backpressure are counted.

Parameters:
- SIZE_FILTER_DATA, 14: base filter width. Shaped data width is W = SIZE_FILTER_DATA+4, signed two's complement.
- TS_WIDTH, 32: timestamp counter width.
- HOLDOFF_CYCLES, 16: cycles spent in HOLDOFF after each reported peak. Must be ≥1.
- LOST_WIDTH, 16: width of the lost-event counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  detection enable.
- filter_data  in  W  signed shaped sample, one per clk.
- threshold  in  W  signed trigger level. Quasi-static; sampled every cycle.
- peak_valid  out  1  event available.
- peak_ready  in  1  readout accepts the event.
- peak_amplitude  out  W  signed maximum sample of the pulse.
- peak_time  out  TS_WIDTH  timestamp of the maximum sample.
- lost_count  out  LOST_WIDTH  saturating count of dropped events.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, ts=0, max=0, max_ts=0, holdoff counter=0.
  - Outputs: peak_valid=0, peak_amplitude=0, peak_time=0, lost_count=0, busy=0.
  - Reset mid-pulse or with peak_valid=1 discards everything. No event is emitted after release.
- Timestamp: ts increments by 1 on every clk edge, independent of enable, and wraps 2^TS_WIDTH-1 -> 0. A sample's timestamp is the ts value present before its capture edge.
- All comparisons are signed, on W bits.
- State machine (evaluated at each edge on the current filter_data):
  - IDLE:
    - filter_data > threshold (strict): go to RISING, max<=filter_data, max_ts<=ts.
    - Otherwise stay in IDLE.
  - RISING:
    - filter_data > max: update max and max_ts.
    - filter_data == max: no update, so the earliest of equal maxima wins.
    - filter_data < max: report the event (below), load holdoff counter with HOLDOFF_CYCLES, go to HOLDOFF.
  - HOLDOFF:
    - Decrement the counter each cycle. No triggering.
    - When the counter reaches 0: go to IDLE if filter_data <= threshold, else go to WAIT_BELOW.
  - WAIT_BELOW: go to IDLE on the first sample <= threshold.
- enable:
  - enable=0 forces the state to IDLE at the next edge from any state. An in-progress RISING pulse is abandoned without an event.
  - An already-pending event is unaffected.
- Event report and latency:
  - The event is written at the same edge that captures the falling sample.
  - peak_valid is visible one cycle after the falling sample was presented.
- Handshake:
  - Transfer occurs on an edge where peak_valid=1 and peak_ready=1.
  - peak_amplitude and peak_time stay stable while peak_valid=1 and peak_ready=0.
  - peak_valid drops after the transfer edge unless a new event is written at that same edge. In that case the new event is loaded and peak_valid stays 1.
  - New event while peak_valid=1 and peak_ready=0: the new event is discarded and the held event is kept. lost_count increments and saturates at all-ones.
- busy = (state != IDLE), registered together with the state.

Test Plan:
- Basic peak: threshold=100, samples from the first edge after reset 0,50,150,300,420,410,200,0..., peak_ready=1 -> one event: peak_amplitude=420, peak_time=4, peak_valid high for exactly one cycle after the edge capturing 410.
- Equal maxima and negative data: threshold=-50, samples -100,-20,80,80,60 -> peak_amplitude=80 with the timestamp of the first 80; a signed threshold below zero triggers on -20.
- Holdoff / re-arm: HOLDOFF_CYCLES=4, pulse peaking at 500 then data held at 200 above threshold=100 -> no second event until data drops <=100 and a new rise occurs. A second pulse after re-arm produces a second event.
- Backpressure: peak_ready=0, three separated pulses -> peak_valid stays 1 holding the first pulse's values, lost_count=2. Raise peak_ready for one cycle -> peak_valid drops.
- Simultaneous accept and new event: peak_ready=1 on the same edge that a second event is written -> first event transferred, second loaded, peak_valid continuously 1, lost_count unchanged.
- Reset/enable/wrap:
  - Reset asserted mid-RISING -> all outputs 0, no event after release.
  - enable=0 mid-pulse -> no event.
  - ts preloaded near 2^TS_WIDTH-1 (or TS_WIDTH=4 build) -> peak_time wraps correctly.
